aes_decrypt: RTL and testbench

//  Iterative AES-256 decryption core (FIPS-197 inverse cipher), one round per clock.

---
 rtl/aes_decrypt.sv | 206 ++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// Iterative AES-256 inverse cipher: one round per clock, with forward key
// expansion into a local round-key store and an optional expanded-key cache.
module aes_decrypt #(
  parameter int unsigned KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ready,
  input  logic [127:0] data_in,
  input  logic [255:0] key,
  output logic [127:0] data_out,
  output logic         valid,
  output logic         busy
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_ADDKEY, S_ROUND, S_FINAL} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k = row + 4*col sits at bits [127-8k -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = isbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        a[r]  = s[127 - 8*(r + 4*c) -: 8];
        x2    = xtime(a[r]);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127 - 32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                             m9[0] ^ me[1] ^ mb[2] ^ md[3],
                             md[0] ^ m9[1] ^ me[2] ^ mb[3],
                             mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return o;
  endfunction

  state_t        state_q;
  logic [3:0]    rnd_q;
  logic [127:0]  ct_q, st_q, data_out_q;
  logic [255:0]  k_q, cached_key_q;
  logic          cache_vld_q, valid_q, busy_q;
  logic [127:0]  rk_q [15];

  logic          hit;
  logic [3:0]    im1, im2;
  logic [127:0]  prev1, prev2, exp_d, sr_sb, round_d, final_d;
  logic [31:0]   w3, t, n0, n1, n2, n3;
  logic [7:0]    rcon;

  assign hit = (KEY_CACHE != 0) && cache_vld_q && (key == cached_key_q);

  always_comb begin
    im1   = rnd_q - 4'd1;
    im2   = rnd_q - 4'd2;
    prev1 = rk_q[im1];
    prev2 = rk_q[im2];
    w3    = prev1[31:0];
    rcon  = 8'h01 << (rnd_q[3:1] - 3'd1);
    if (!rnd_q[0]) t = subword({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
    else           t = subword(w3);
    n0      = prev2[127:96] ^ t;
    n1      = prev2[95:64]  ^ n0;
    n2      = prev2[63:32]  ^ n1;
    n3      = prev2[31:0]   ^ n2;
    exp_d   = {n0, n1, n2, n3};
    sr_sb   = inv_shift_sub(st_q);
    round_d = inv_mix(sr_sb ^ rk_q[rnd_q]);
    final_d = sr_sb ^ rk_q[0];
  end

  // Key store carries no reset: its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && ready && !hit) begin
      rk_q[0] <= key[255:128];
      rk_q[1] <= key[127:0];
    end else if (state_q == S_EXPAND) begin
      rk_q[rnd_q] <= exp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rnd_q        <= '0;
      ct_q         <= '0;
      st_q         <= '0;
      k_q          <= '0;
      cached_key_q <= '0;
      cache_vld_q  <= 1'b0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ready) begin
            ct_q   <= data_in;
            k_q    <= key;
            busy_q <= 1'b1;
            if (hit) begin
              state_q <= S_ADDKEY;
            end else begin
              cache_vld_q <= 1'b0;
              rnd_q       <= 4'd2;
              state_q     <= S_EXPAND;
            end
          end
        end
        S_EXPAND: begin
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'd14) begin
            cached_key_q <= k_q;
            cache_vld_q  <= 1'b1;
            rnd_q        <= 4'd13;
            state_q      <= S_ADDKEY;
          end
        end
        S_ADDKEY: begin
          st_q    <= ct_q ^ rk_q[14];
          rnd_q   <= 4'd13;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          st_q  <= round_d;
          rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) state_q <= S_FINAL;
        end
        S_FINAL: begin
          data_out_q <= final_d;
          valid_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: known-answer vectors, cache/latency, busy, abort and
// random round-trips through a table-free AES-256 encrypt model.
module tb_aes_decrypt;

  localparam logic [255:0] T1K = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] T1C = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] T1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] T2K = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] T2C = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] T2P = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] T3C = 128'h591ccb10d410ed26dc5ba74a31362870;
  localparam logic [127:0] T3P = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, rdy_a, rdy_b;
  logic [127:0] din;
  logic [255:0] kin;
  logic [127:0] dout_a, dout_b;
  logic         val_a, val_b, busy_a, busy_b;

  aes_decrypt #(.KEY_CACHE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ready(rdy_a), .data_in(din), .key(kin),
    .data_out(dout_a), .valid(val_a), .busy(busy_a)
  );

  aes_decrypt #(.KEY_CACHE(0)) u_nc (
    .clk(clk), .rst_n(rst_n), .ready(rdy_b), .data_in(din), .key(kin),
    .data_out(dout_b), .valid(val_b), .busy(busy_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb [256];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3, rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127 - 8*j -: 8];
    for (int rn = 0; rn <= 14; rn++) begin
      if (rn > 0) begin
        for (int j = 0; j < 16; j++) t[j] = sb[s[j]];
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
        if (rn < 14) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r + 4*c] ^= w[4*rn + c][31 - 8*r -: 8];
    end
    for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = s[j];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Call at a falling edge with the selected DUT idle; returns at a falling edge.
  task automatic run_blk(input bit sel, input logic [255:0] k, input logic [127:0] ct,
                         input logic [127:0] exp_pt, input int exp_edges,
                         input bit hold, input bit wiggle, input string tag);
    int lat;
    bit seen;
    chk({tag, "/idle"}, sel ? busy_b : busy_a, 0);
    din = ct;
    kin = k;
    if (sel) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin rdy_a = 1'b0; rdy_b = 1'b0; end
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (sel ? val_b : val_a) begin
        seen = 1'b1;
      end else begin
        if (lat == 2) chk({tag, "/busy"}, sel ? busy_b : busy_a, 1);
        if (wiggle) begin
          din = rnd128();
          kin = {rnd128(), rnd128()};
          if (sel) rdy_b = 1'($urandom_range(0, 1)); else rdy_a = 1'($urandom_range(0, 1));
        end
      end
    end
    chk({tag, "/valid"}, seen, 1);
    chk({tag, "/latency"}, lat - 1, exp_edges);
    chk({tag, "/pt"}, sel ? dout_b : dout_a, exp_pt);
    chk({tag, "/busy_done"}, sel ? busy_b : busy_a, 0);
    if (!hold) begin
      rdy_a = 1'b0;
      rdy_b = 1'b0;
      @(negedge clk);
      chk({tag, "/pulse"}, sel ? val_b : val_a, 0);
    end
  endtask

  initial begin
    logic [255:0] k, last_k;
    logic [127:0] pt;

    rst_n = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0; din = '0; kin = '0;
    build_sbox();
    if (ref_enc(T1K, T1P) !== T1C) begin
      $display("FAIL model: encrypt reference disagrees with known answer");
      $fatal(1);
    end

    repeat (2) @(negedge clk);
    chk("rst/data_out", dout_a, 0);
    chk("rst/valid", val_a, 0);
    chk("rst/busy", busy_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_blk(0, T1K, T1C, T1P, 28, 0, 0, "T1");
    run_blk(0, T1K, T1C, T1P, 15, 0, 0, "T1hit");
    run_blk(0, T2K, T2C, T2P, 28, 0, 0, "T2");
    run_blk(0, T2K, T3C, T3P, 15, 0, 0, "T3");
    run_blk(1, T2K, T2C, T2P, 28, 0, 0, "T2nc");
    run_blk(1, T2K, T3C, T3P, 28, 0, 0, "T3nc");

    k  = {rnd128(), rnd128()};
    pt = rnd128();
    run_blk(0, k, ref_enc(k, pt), pt, 28, 0, 1, "T4miss");
    pt = rnd128();
    run_blk(0, k, ref_enc(k, pt), pt, 15, 0, 1, "T4hit");

    din = T1C; kin = T1K; rdy_a = 1'b1;
    @(posedge clk);
    #1 rdy_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("T5/busy_before", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk("T5/rst_valid", val_a, 0);
    chk("T5/rst_data", dout_a, 0);
    chk("T5/rst_busy", busy_a, 0);
    @(negedge clk);
    chk("T5/rst_valid2", val_a, 0);
    chk("T5/rst_data2", dout_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_blk(0, T1K, T1C, T1P, 28, 0, 0, "T5");

    last_k = T1K;
    for (int n = 0; n < 1000; n++) begin
      if (n == 0 || $urandom_range(0, 2) == 0) k = {rnd128(), rnd128()};
      pt = rnd128();
      run_blk(0, k, ref_enc(k, pt), pt, (k == last_k) ? 15 : 28, 1, 0, "T6");
      last_k = k;
    end
    rdy_a = 1'b0;
    @(negedge clk);
    chk("T6/end_pulse", val_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
